wallace_mult_pipe: RTL

//   Parametrised, pipelined Wallace-tree integer multiplier with a valid/ready stream interface.

---
 rtl/wallace_mult_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier (signed/unsigned per op) with a valid/ready stream
// interface. The 3:2 reduction levels are spread over the leading stages; the last stage does the CPA.
module wallace_mult_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PW = 2 * WIDTH;
  localparam int R  = WIDTH + 1;

  // Rows remaining after lvl word-level 3:2 levels (WIDTH partial products + constant row).
  function automatic int rows_at(input int lvl);
    int n;
    n = WIDTH + 1;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int num_levels(input int w);
    int n;
    int l;
    n = w + 1;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int L = num_levels(WIDTH);
  localparam int T = STAGES - 1;

  // Stage whose register captures the rows of level lvl; 0 when that level is not registered.
  function automatic int reg_stage(input int lvl);
    int e;
    e = 0;
    for (int s = 1; s <= T; s++) begin
      e += L / (T > 0 ? T : 1) + ((s <= L % (T > 0 ? T : 1)) ? 1 : 0);
      if (e == lvl) return s;
    end
    return 0;
  endfunction

  logic                      stall;
  logic                      accept;
  logic [STAGES:1]           valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q [1:STAGES];
  logic [TAG_W-1:0]          tag_d [1:STAGES];
  logic [PW-1:0]             product_q, product_d;
  logic [PW-1:0]             bw_const;
  logic [R-1:0][PW-1:0]      lvl_out [0:L];
  logic [R-1:0][PW-1:0]      lvl_in  [0:L];

  assign stall       = valid_q[STAGES] && !out_ready;
  assign in_ready    = !stall;
  assign accept      = in_valid && !stall;
  assign out_valid   = valid_q[STAGES];
  assign out_product = product_q;
  assign out_tag     = tag_q[STAGES];

  genvar gi, gr;
  generate
    // Baugh-Wooley: terms mixing exactly one operand MSB are inverted in signed mode.
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      logic [PW-1:0] pp_row;
      always_comb begin
        pp_row = '0;
        for (int j = 0; j < WIDTH; j++) begin
          pp_row[gi + j] = (in_a[j] & in_b[gi]) ^ (in_signed & ((gi == WIDTH - 1) != (j == WIDTH - 1)));
        end
      end
      assign lvl_out[0][gi] = pp_row;
    end
  endgenerate

  always_comb begin
    bw_const           = '0;
    bw_const[WIDTH]    = in_signed;
    bw_const[PW - 1]   = in_signed;
  end
  assign lvl_out[0][WIDTH] = bw_const;

  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      if (reg_stage(gi) != 0) begin : g_reg
        logic [R-1:0][PW-1:0] rows_q, rows_d;
        always_comb begin
          rows_d = rows_q;
          if (!stall) rows_d = lvl_out[gi];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) rows_q <= '0;
          else        rows_q <= rows_d;
        end
        assign lvl_in[gi] = rows_q;
      end else begin : g_pass
        assign lvl_in[gi] = lvl_out[gi];
      end

      if (gi < L) begin : g_csa
        localparam int N  = rows_at(gi);
        localparam int G  = N / 3;
        localparam int NN = rows_at(gi + 1);
        for (gr = 0; gr < R; gr++) begin : g_row
          if (gr < 2 * G) begin : g_add
            logic [PW-1:0] x, y, z, maj;
            assign x   = lvl_in[gi][3 * (gr / 2)];
            assign y   = lvl_in[gi][3 * (gr / 2) + 1];
            assign z   = lvl_in[gi][3 * (gr / 2) + 2];
            assign maj = (x & y) | (x & z) | (y & z);
            if (gr % 2 == 0) begin : g_sum
              assign lvl_out[gi + 1][gr] = x ^ y ^ z;
            end else begin : g_cy
              // Carry out of the top bit is dropped: the product is modulo 2^PW.
              assign lvl_out[gi + 1][gr] = {maj[PW-2:0], 1'b0};
            end
          end else if (gr < NN) begin : g_copy
            assign lvl_out[gi + 1][gr] = lvl_in[gi][gr + G];
          end else begin : g_zero
            assign lvl_out[gi + 1][gr] = '0;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    product_d = product_q;
    if (!stall) begin
      valid_d[1] = accept;
      for (int s = 2; s <= STAGES; s++) valid_d[s] = valid_q[s - 1];
      if (accept) tag_d[1] = in_tag;
      for (int s = 2; s <= STAGES; s++) begin
        if (valid_q[s - 1]) tag_d[s] = tag_q[s - 1];
      end
      // Output only updates for a real op so it holds across bubbles.
      if (valid_d[STAGES]) product_d = lvl_in[L][0] + lvl_in[L][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      product_q <= '0;
      for (int s = 1; s <= STAGES; s++) tag_q[s] <= '0;
    end else begin
      valid_q   <= valid_d;
      product_q <= product_d;
      tag_q     <= tag_d;
    end
  end
endmodule
